// File: rtl/imem_dmem_port_arbiter_pkg.sv
// Shared constants for the unified instruction/data memory port arbiter.
// FSM state and owner encodings, plus the global ON/OFF/ZERO values.
package imem_dmem_port_arbiter_pkg;

  localparam logic        ON   = 1'b1;
  localparam logic        OFF  = 1'b0;
  localparam logic [31:0] ZERO = 32'd0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

endpackage

// File: rtl/imem_dmem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational.
// last_d = 1 means the data side won the previous grant.
module imem_dmem_port_arbiter_rr_arbiter2
  import imem_dmem_port_arbiter_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_d,
  output logic grant_i,
  output logic grant_d,
  output logic last_d_next
);

  always_comb begin
    grant_i     = OFF;
    grant_d     = OFF;
    last_d_next = last_d;
    if (req_i && req_d) begin
      if (last_d) grant_i = ON;
      else        grant_d = ON;
    end else if (req_i) begin
      grant_i = ON;
    end else if (req_d) begin
      grant_d = ON;
    end
    if (grant_d)      last_d_next = ON;
    else if (grant_i) last_d_next = OFF;
  end

endmodule

// File: rtl/imem_dmem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Each access runs IDLE/DONE -> ISSUE -> (WAIT) -> DONE; DONE re-arbitrates.
module imem_dmem_port_arbiter
  import imem_dmem_port_arbiter_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter bit PRIO_DATA  = 1'b1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iIReq,
  input  logic [31:0] iIAddress,
  output logic        oIValid,
  output logic [31:0] oIReadData,
  input  logic        iDReq,
  input  logic        iDWrite,
  input  logic [3:0]  iDByteEnable,
  input  logic [31:0] iDAddress,
  input  logic [31:0] iDWriteData,
  output logic        oDValid,
  output logic [31:0] oDReadData,
  output logic        oMReadEnable,
  output logic        oMWriteEnable,
  output logic [3:0]  oMByteEnable,
  output logic [31:0] oMAddress,
  output logic [31:0] oMWriteData,
  input  logic [31:0] iMReadData,
  output logic        oStall,
  output logic [1:0]  oBusyOwner
);

  localparam logic [2:0] CNT_RELOAD = 3'(RD_LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        last_d_q, last_d_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic arb_en, in_done, in_issue;
  logic req_i, req_d, grant_i, grant_d, last_d_next;
  logic i_valid, d_valid;

  assign arb_en   = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign in_done  = (state_q == ST_DONE);
  assign in_issue = (state_q == ST_ISSUE);

  // The owner completing in DONE still holds its request this cycle; it must not win again.
  assign req_i = arb_en & iIReq & ~(in_done & (owner_q == OWN_I));
  assign req_d = arb_en & iDReq & ~(in_done & (owner_q == OWN_D));

  imem_dmem_port_arbiter_rr_arbiter2 u_rr_arbiter2 (
    .req_i       (req_i),
    .req_d       (req_d),
    .last_d      (last_d_q),
    .grant_i     (grant_i),
    .grant_d     (grant_d),
    .last_d_next (last_d_next)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    write_d   = write_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    last_d_d  = last_d_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (grant_i || grant_d) begin
          state_d  = ST_ISSUE;
          last_d_d = last_d_next;
          if (grant_d) begin
            owner_d = OWN_D;
            addr_d  = iDAddress;
            write_d = iDWrite;
            be_d    = iDByteEnable;
            wdata_d = iDWriteData;
          end else begin
            owner_d = OWN_I;
            addr_d  = iIAddress;
            write_d = OFF;
            be_d    = 4'hF;
            wdata_d = ZERO;
          end
        end
      end
      ST_ISSUE: begin
        if (write_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_RELOAD;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_DONE;
          if (owner_q == OWN_D) d_rdata_d = iMReadData;
          else                  i_rdata_d = iMReadData;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_NONE;
      addr_q    <= ZERO;
      write_q   <= OFF;
      be_q      <= 4'h0;
      wdata_q   <= ZERO;
      cnt_q     <= 3'd0;
      last_d_q  <= ~PRIO_DATA;
      i_rdata_q <= ZERO;
      d_rdata_q <= ZERO;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      last_d_q  <= last_d_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign i_valid = in_done && (owner_q == OWN_I);
  assign d_valid = in_done && (owner_q == OWN_D);

  assign oIValid       = i_valid;
  assign oDValid       = d_valid;
  assign oIReadData    = i_rdata_q;
  assign oDReadData    = d_rdata_q;
  assign oMReadEnable  = in_issue & ~write_q;
  assign oMWriteEnable = in_issue & write_q;
  assign oMByteEnable  = in_issue ? (write_q ? be_q : 4'hF) : 4'h0;
  assign oMAddress     = addr_q;
  assign oMWriteData   = wdata_q;
  // Gated by reset so every output reads 0 while iRST is held.
  assign oStall        = ~iRST & ((iIReq & ~i_valid) | (iDReq & ~d_valid));
  assign oBusyOwner    = (state_q == ST_IDLE) ? OWN_NONE : owner_q;

endmodule

// File: doc/imem_dmem_port_arbiter.md
Name: imem_dmem_port_arbiter

Overview:
Shares one single-port 32-bit memory between the processor's instruction-fetch bus and data bus. Used when the datapath is built against a unified memory instead of separate instruction and data memories. Sequences each access through a small FSM with configurable read latency and returns per-requester valid pulses. Also produces a stall signal so the core holds PC and register writes until both pending accesses have completed.

Parameters:
RD_LATENCY, 1, cycles from the memory issue cycle to read data valid on iMReadData (range 1-7).
PRIO_DATA, 1, tie-break on the first simultaneous request after reset: 1 means data wins, 0 means instruction wins.

Ports:
iCLK  in  1  system clock
iRST  in  1  asynchronous active-high reset
iIReq  in  1  instruction read request; held high until oIValid
iIAddress  in  32  instruction address
oIValid  out  1  one-cycle pulse: oIReadData is valid
oIReadData  out  32  fetched word (registered)
iDReq  in  1  data request; held high until oDValid
iDWrite  in  1  1 means write, 0 means read
iDByteEnable  in  4  byte lanes for a write
iDAddress  in  32  data address
iDWriteData  in  32  store data
oDValid  out  1  one-cycle pulse: data access complete
oDReadData  out  32  loaded word (registered)
oMReadEnable  out  1  memory read strobe
oMWriteEnable  out  1  memory write strobe
oMByteEnable  out  4  memory byte enables
oMAddress  out  32  memory address
oMWriteData  out  32  memory write data
iMReadData  in  32  memory read data
oStall  out  1  core must not advance
oBusyOwner  out  2  owner of the current access: 0 none, 1 instruction, 2 data (debug)

Behaviour:
- Clock and reset: one clock, iCLK; reset is asynchronous and active-high, iRST. While iRST is high and on its release, all outputs are 0, the FSM is in IDLE and the round-robin pointer is set from PRIO_DATA.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- Arbitration in IDLE or DONE:
  - Only one request pending: grant it.
  - Both pending: grant the one not granted last (round robin). Before any grant, use PRIO_DATA.
  - On grant: latch owner, address, write flag, byte enables and write data into command registers; next state is ISSUE.
  - No request: next state is IDLE.
- ISSUE, exactly one cycle:
  - Memory outputs driven from the command registers. oMReadEnable = ~write; oMWriteEnable = write.
  - oMByteEnable = 4'b1111 for reads; the latched byte enables for writes.
  - Next state: DONE for a write; WAIT for a read, with the latency counter loaded to RD_LATENCY-1.
- WAIT:
  - All memory strobes are 0; address and data stay stable.
  - The counter decrements each cycle. When it reaches 0, capture iMReadData into the owner's ReadData register and go to DONE.
  - For RD_LATENCY=1, WAIT lasts one cycle.
- DONE:
  - The owner's Valid is high for exactly one cycle.
  - Arbitration runs in the same cycle, so back-to-back accesses have no idle bubble.
- Latency from request high to Valid high, with the arbiter idle:
  - Write: 2 cycles.
  - Read: 2+RD_LATENCY cycles (3 for the default).
- Read-data registers hold their last value until overwritten. The non-owner's ReadData and Valid are unchanged and low respectively.
- Requests dropped before Valid:
  - If a request is dropped after its grant, the access still completes and Valid still pulses; the requester ignores it.
  - If a request is dropped before its grant, it is never issued.
- oStall = (iIReq & ~oIValid) | (iDReq & ~oDValid), combinational.
- Address and data inputs are sampled only at grant. Later changes do not affect an in-flight access.
- Reset mid-access: the access is aborted and no Valid is produced. The memory may have already performed a write; this is acceptable.
- Addresses pass through unmodified. Alignment is handled by the load/store units upstream.

Decomposition:
- Shared package holds:
  - State encoding constants: ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_WAIT=2'd2, ST_DONE=2'd3.
  - Owner encoding: OWN_NONE=0, OWN_I=1, OWN_D=2.
  - ON/OFF/ZERO, from the existing global parameter header.
- One natural sub-module: rr_arbiter2. Inputs: two requests and the last-grant pointer. Outputs: grant and next pointer. It is purely combinational and reusable.
- The FSM, command registers and latency counter stay in the top module.

Test Plan:
- Single instruction read, RD_LATENCY=1: iIReq=1 at cycle 0 with iIAddress=0x00400000, memory returns 0x00500093. Required: oMReadEnable=1 with oMAddress=0x00400000 in cycle 1; oIValid=1 with oIReadData=0x00500093 in cycle 3; oStall=1 in cycles 0-2 and 0 in cycle 3.
- Data write: iDReq=1, iDWrite=1, iDAddress=0x10010004, iDWriteData=0xDEADBEEF, iDByteEnable=4'b0011. Required: oMWriteEnable=1 and oMByteEnable=0011 in cycle 1 only; oDValid=1 in cycle 2; oMReadEnable stays 0 throughout.
- Simultaneous requests after reset with PRIO_DATA=1, both held continuously. Required: data is served first, then instruction, then data again, alternating. ISSUE cycles fall at cycles 1, 4, 7 for a read/read mix with no idle cycles between them.
- RD_LATENCY=4 read. Required: oMReadEnable high for exactly one cycle; Valid at cycle 6; changing iIAddress during WAIT does not change oMAddress.
- iRST asserted in WAIT, then released. Required: all outputs go to 0 immediately; no Valid pulse; the FSM is in IDLE; a new request is then served with normal latency.
- Request dropped after grant: iIReq falls in cycle 2. Required: oIValid still pulses in cycle 3, and the next pending iDReq is granted in that same cycle.
